// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer/checker for the conv-encoder / channel / Viterbi-decoder path.
// Feeds one frame of source bits plus zero tail bits into the encoder.
// Keeps the encoder clocked until the decoder latency has drained.
// Compares the aligned decoded bits against a stored copy of what was sent.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           in_valid_i,
    input  logic                           in_bit_i,
    output logic                           in_ready_o,
    output logic                           enc_en_o,
    output logic                           enc_bit_o,
    output logic                           dp_clr_o,
    input  logic                           dec_i,
    output logic                           out_valid_o,
    output logic                           out_bit_o,
    output logic                           out_err_o,
    output logic                           frame_done_o,
    output logic                           busy_o,
    output logic                           underrun_o,
    output logic [$clog2(FRAME_LEN+1)-1:0] frame_errs_o,
    output logic [31:0]                    total_errs_o,
    output logic [15:0]                    frame_cnt_o
);

    localparam int FEW = $clog2(FRAME_LEN + 1);
    localparam int CW  = $clog2(DEC_LAT + FRAME_LEN + 1);
    localparam int IW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CW-1:0] FEED_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(FRAME_LEN + TAIL_LEN - 1);
    localparam logic [CW-1:0] CAP_FIRST = CW'(DEC_LAT);
    localparam logic [CW-1:0] CAP_LAST  = CW'(DEC_LAT + FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        FEED,
        TAIL,
        FLUSH,
        DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        cyc;
    logic [FRAME_LEN-1:0] frame_buf;

    logic          in_feed;
    logic          enc_active;
    logic          send_bit;
    logic          capture;
    logic          cap_mismatch;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    // Datapath-facing decode of the current state and capture window
    always_comb begin
        in_feed      = (state == FEED);
        enc_active   = (state == FEED) || (state == TAIL) || (state == FLUSH);
        send_bit     = in_feed && in_valid_i && in_bit_i;
        capture      = enc_active && (cyc >= CAP_FIRST) && (cyc <= CAP_LAST);
        wr_idx       = IW'(cyc);
        rd_idx       = IW'(cyc - CAP_FIRST);
        cap_mismatch = capture && (dec_i != frame_buf[rd_idx]);
    end

    assign in_ready_o   = in_feed;
    assign enc_en_o     = enc_active;
    assign enc_bit_o    = send_bit;
    assign dp_clr_o     = (state == PREP);
    assign busy_o       = (state != IDLE);
    assign frame_done_o = (state == DONE);

    // Copy of the bits actually sent; read index always trails the write index
    always_ff @(posedge clk) begin
        if (in_feed)
            frame_buf[wr_idx] <= send_bit;
    end

    // Frame sequencing, capture registers and error scoreboards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cyc          <= '0;
            underrun_o   <= 1'b0;
            frame_errs_o <= '0;
            total_errs_o <= '0;
            frame_cnt_o  <= '0;
            out_valid_o  <= 1'b0;
            out_bit_o    <= 1'b0;
            out_err_o    <= 1'b0;
        end else begin
            out_valid_o <= capture;
            out_bit_o   <= capture && dec_i;
            out_err_o   <= cap_mismatch;

            if (cap_mismatch) begin
                frame_errs_o <= frame_errs_o + FEW'(1);
                if (total_errs_o != '1)
                    total_errs_o <= total_errs_o + 32'd1;
            end

            if (enc_active)
                cyc <= cyc + CW'(1);

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= PREP;
                        cyc          <= '0;
                        underrun_o   <= 1'b0;
                        frame_errs_o <= '0;
                    end
                end
                PREP: state <= FEED;
                FEED: begin
                    if (!in_valid_i)
                        underrun_o <= 1'b1;
                    if (cyc == FEED_LAST)
                        state <= (TAIL_LEN == 0) ? FLUSH : TAIL;
                end
                // Last capture may land inside the tail, in which case FLUSH is skipped
                TAIL: begin
                    if (cyc == CAP_LAST) begin
                        state       <= DONE;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                    end else if (cyc == TAIL_LAST) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cyc == CAP_LAST) begin
                        state       <= DONE;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
